// File: rtl/fb_rect_writer.sv
// fb_rect_writer: clips one solid-colour rectangle to the screen and fills it into a
// row-major framebuffer at one registered pixel write per clock.
module fb_rect_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [9:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [9:0]        cmd_h,
    input  logic [11:0]       cmd_color,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              we
);
    typedef enum logic [2:0] {IDLE, SETUP, ROW, NEXT_ROW, DONE} state_t;
    state_t            state_q, state_d;
    logic [9:0]        x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [9:0]        cw_q, cw_d, ch_q, ch_d, pix_q, pix_d, row_q, row_d;
    logic [11:0]       color_q, color_d;
    logic [ADDR_W-1:0] addr_q, addr_d, row_base_q, row_base_d;
    logic              we_q;
    logic [10:0]       x_room, y_room;
    logic [9:0]        cw, ch;
    logic [ADDR_W-1:0] base, stride;
    logic              clipped, last_pix, last_row;

    assign x_room   = 11'(H_RES) - {1'b0, x_q};
    assign y_room   = 11'(V_RES) - {1'b0, y_q};
    assign cw       = ({1'b0, w_q} < x_room) ? w_q : x_room[9:0];
    assign ch       = ({1'b0, h_q} < y_room) ? h_q : y_room[9:0];
    assign clipped  = ({1'b0, x_q} >= 11'(H_RES)) || ({1'b0, y_q} >= 11'(V_RES)) || (w_q == 10'd0) || (h_q == 10'd0);
    // Row stride of 640 words = 512 + 128, so y*640 needs no multiplier.
    assign base     = (ADDR_W'(y_q) << 9) + (ADDR_W'(y_q) << 7) + ADDR_W'(x_q);
    assign stride   = ADDR_W'(H_RES);
    assign last_pix = pix_q == cw_q - 10'd1;
    assign last_row = row_q == ch_q - 10'd1;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        cw_d       = cw_q;
        ch_d       = ch_q;
        pix_d      = pix_q;
        row_d      = row_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    color_d = cmd_color;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cw_d       = cw;
                ch_d       = ch;
                pix_d      = 10'd0;
                row_d      = 10'd0;
                // An off-screen base is never exposed on w_addr.
                addr_d     = clipped ? addr_q : base;
                row_base_d = clipped ? row_base_q : base;
                state_d    = clipped ? DONE : ROW;
            end
            ROW: begin
                pix_d   = last_pix ? 10'd0 : pix_q + 10'd1;
                addr_d  = last_pix ? addr_q : addr_q + 1'b1;
                state_d = !last_pix ? ROW : (last_row ? DONE : NEXT_ROW);
            end
            NEXT_ROW: begin
                row_base_d = row_base_q + stride;
                addr_d     = row_base_q + stride;
                row_d      = row_q + 10'd1;
                state_d    = ROW;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            cw_q       <= '0;
            ch_q       <= '0;
            pix_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            row_base_q <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            cw_q       <= cw_d;
            ch_q       <= ch_d;
            pix_q      <= pix_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            row_base_q <= row_base_d;
            we_q       <= state_d == ROW;
        end
    end

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign w_addr    = addr_q;
    assign w_data    = DATA_W'(color_q);
    assign we        = we_q;
endmodule

// File: tb/tb_fb_rect_writer.sv
// tb_fb_rect_writer: random and directed rectangle fills against a pixel-list model;
// expected writes/done pulses are queued on accept and popped by a negedge monitor.
module tb_fb_rect_writer;
    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, busy, done, we;
    logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
    logic [11:0] cmd_color;
    logic [18:0] w_addr;
    logic [15:0] w_data;

    fb_rect_writer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .busy(busy), .done(done), .w_addr(w_addr), .w_data(w_data), .we(we)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int data; int cyc;} wr_t;
    wr_t wq[$];
    int  dq[$];
    int  cyc = 0, n_chk = 0, n_fail = 0, n_acc = 0;
    int  busy_from = 0, ready_from = 0;
    bit  armed = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference model: on each accepted command, enumerate the clipped pixels in raster order.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            if (armed) chk("ready_in_rst", 32'(cmd_ready), 0);
            wq.delete();
            dq.delete();
            busy_from  = cyc + 1;
            ready_from = cyc + 1;
            armed      = 1;
        end else if (armed) begin
            bit rdy;
            rdy = cyc >= ready_from;
            chk("cmd_ready", 32'(cmd_ready), 32'(rdy));
            chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc < ready_from));
            if (cmd_valid && rdy) begin
                int x, y, w, h, cw, ch, d;
                x  = int'(cmd_x);
                y  = int'(cmd_y);
                w  = int'(cmd_w);
                h  = int'(cmd_h);
                cw = (x >= 640) ? 0 : ((w < 640 - x) ? w : 640 - x);
                ch = (y >= 480) ? 0 : ((h < 480 - y) ? h : 480 - y);
                if (cw == 0 || ch == 0) d = cyc + 2;
                else begin
                    for (int r = 0; r < ch; r++)
                        for (int p = 0; p < cw; p++)
                            wq.push_back('{(y + r) * 640 + x + p, int'(cmd_color), cyc + 2 + r * (cw + 1) + p});
                    d = cyc + cw * ch + ch + 1;
                end
                dq.push_back(d);
                busy_from  = cyc + 1;
                ready_from = d + 1;
                n_acc++;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            wr_t e;
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                chk("write_missing_cycle", cyc, wq[0].cyc);
                void'(wq.pop_front());
            end
            while (dq.size() > 0 && dq[0] < cyc) begin
                chk("done_missing_cycle", cyc, dq[0]);
                void'(dq.pop_front());
            end
            if (we) begin
                if (wq.size() == 0) chk("unexpected_write_addr", 32'(w_addr), 32'hFFFF_FFFF);
                else begin
                    e = wq.pop_front();
                    chk("w_addr", 32'(w_addr), e.addr);
                    chk("w_data", 32'(w_data), e.data);
                    chk("write_cycle", cyc, e.cyc);
                end
            end
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_cycle", cyc, dq.pop_front());
            end
        end
    end

    task automatic send(input int x, input int y, input int w, input int h, input int c);
        int  n0;
        bit  ok;
        n0 = n_acc;
        ok = 0;
        @(posedge clk);
        #1;
        cmd_x     = 10'(x);
        cmd_y     = 10'(y);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = 12'(c);
        cmd_valid = 1'b1;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(posedge clk);
            ok = n_acc != n0;
        end
        #1;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        cmd_valid = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = cyc > ready_from;
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_we", 32'(we), 0);
        chk("rst_w_addr", 32'(w_addr), 0);
        chk("rst_w_data", 32'(w_data), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        send(2, 1, 3, 2, 'hF00);         wait_idle();
        send(638, 479, 5, 4, 'h0A5);     wait_idle();
        send(5, 5, 0, 3, 'h001);         wait_idle();
        send(700, 5, 3, 3, 'h002);       wait_idle();
        send(0, 0, 1, 1, 'hFFF);         wait_idle();
        send(10, 10, 4, 3, 'h123);
        send(20, 20, 2, 2, 'h456);       wait_idle();
        send(100, 50, 10, 10, 'h777);
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send(1, 2, 3, 3, 'hABC);         wait_idle();
        for (int k = 0; k < 30; k++) begin
            int x, y;
            x = $urandom_range(0, 1) ? int'($urandom_range(600, 700)) : int'($urandom_range(0, 639));
            y = $urandom_range(0, 1) ? int'($urandom_range(460, 500)) : int'($urandom_range(0, 479));
            send(x, y, int'($urandom_range(0, 40)), int'($urandom_range(0, 6)), int'($urandom_range(0, 4095)));
            if (k == 29 || $urandom_range(0, 1) == 1) wait_idle();
        end
        repeat (20) @(posedge clk);
        #1;
        chk("writes_left", wq.size(), 0);
        chk("dones_left", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_rect_writer.md
# fb_rect_writer

Framebuffer fill engine that rasterises solid-colour rectangles into the 640x480 display framebuffer. It drives the write port of the dual-port frame RAM whose read port is scanned by the VGA output block. It accepts one rectangle command at a time over a valid/ready handshake, clips it to the screen, and emits one pixel write per clock. The game logic uses it to draw or clear screen regions.

## Interface
- H_RES, 640, visible pixels per line; also the row stride in words
- V_RES, 480, visible lines
- ADDR_W, 19, framebuffer word-address width
- DATA_W, 16, framebuffer word width; colour occupies [11:0]
- clk  in  1  system clock (100 MHz); every register on its rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle and able to accept a command
- cmd_x, cmd_y  in  10 each  top-left pixel coordinate
- cmd_w, cmd_h  in  10 each  rectangle width and height in pixels
- cmd_color  in  12  RGB444 fill colour
- busy  out  1  command in progress (state != IDLE)
- done  out  1  one-cycle pulse when a command completes
- w_addr  out  ADDR_W  framebuffer write address, row-major, y*H_RES+x
- w_data  out  DATA_W  {4'b0, colour}
- we  out  1  write strobe; exactly one word is written per cycle while high

## Operation
- States: IDLE, SETUP, ROW, NEXT_ROW, DONE.
- IDLE: cmd_ready=1. A command is accepted on a clock edge where cmd_valid && cmd_ready. On that edge, x, y, w, h and colour are latched and the state moves to SETUP. In every other state cmd_valid is ignored, and there is no queueing.
- SETUP: compute clipped sizes using 11-bit sums. cw = min(w, H_RES-x) and ch = min(h, V_RES-y). Compute base = y*H_RES + x using shift-add (y<<9 + y<<7 for 640). If x>=H_RES, y>=V_RES, w==0 or h==0, go to DONE with no writes. Otherwise go to ROW, with w_addr=base, pixel count=0 and row count=0.
- ROW: we=1, w_addr incremented by 1 each cycle, cw writes per row.
  - After the last pixel of a row that is not the final row, go to NEXT_ROW.
  - After the last pixel of the final row, go to DONE.
- NEXT_ROW: we=0 for one cycle. Set w_addr = row start + H_RES, then return to ROW.
- DONE: done=1 for exactly one cycle, then IDLE.
- w_data = {4'b0, latched colour}, constant for the whole command.
- Addresses never leave the range [0, H_RES*V_RES-1].
- rst while in any state: on that edge the state goes to IDLE and every output goes to its reset value. No further writes occur and done is not pulsed for the aborted command.

## Timing
- Reset values: we=0, w_addr=0, w_data=0, done=0, busy=0. cmd_ready=0 while rst is high and 1 from the first cycle after rst deasserts.
- Cycle numbering: the accept edge ends cycle 0.
  - Cycle 1: SETUP.
  - First write (we=1) in cycle 2.
  - Rows are separated by one idle cycle (we=0).
- done is high in cycle cw*ch + ch + 1. For a fully clipped or empty rectangle, done is high in cycle 2.
- cmd_ready returns high in the cycle after done. The earliest next accept is therefore at the end of that cycle.
- Sustained throughput: 1 pixel/clk within a row.
- The RAM write port samples on the falling clk edge, so w_addr, w_data and we are all registered and stable for the full cycle.

## Test plan
- Reset, then rst=0 with cmd_valid=0 -> we=0, w_addr=0, done=0, busy=0; cmd_ready=1 from the first cycle after rst deasserts.
- Command x=2, y=1, w=3, h=2, color=0xF00 -> the following occur:
  - Writes to 642, 643, 644 in cycles 2–4, with w_data=0x0F00.
  - we=0 in cycle 5.
  - Writes to 1282, 1283, 1284 in cycles 6–8.
  - done in cycle 9, with exactly 6 writes in total.
- Clipping: x=638, y=479, w=5, h=4, color=0x0A5 -> only 307198 and 307199 are written; done in cycle 4.
- Degenerate: w=0 (and separately x=700) -> no writes; done in cycle 2; cmd_ready=1 in cycle 3.
- Back-to-back: cmd_valid held high with a second command during the first -> the second command is ignored while busy. It is accepted at the end of the cycle after done, and its first write appears 2 cycles later.
- Abort: assert rst during the third write of a 10x10 fill -> we=0 from the next cycle and no done pulse. A new command after reset executes normally.
